// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle.
//
// Groups the per-master request/grant lines with the already-muxed address
// strobe and slave ready so the arbiter and its surroundings share one port.
//
//   m_req       per-master request level, held for the whole tenure
//   m_as        address strobe of the current owner (muxed)
//   s_ready     ready of the selected slave (muxed), low when none selected
//   m_grnt      one-hot grant, zero when nobody owns the bus
//   owner       index of the granted or last-granted master
//   bus_busy    high while a master owns the bus
//   bus_timeout one-cycle pulse when the watchdog aborts a transfer
//
// Modports:
//   slave  - the arbiter's view (consumes requests, drives grants)
//   master - the view of the surrounding bus logic / testbench
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = $clog2(NUM_MASTERS)
) ();

  logic [NUM_MASTERS-1:0] m_req;
  logic                   m_as;
  logic                   s_ready;
  logic [NUM_MASTERS-1:0] m_grnt;
  logic [OWNER_W-1:0]     owner;
  logic                   bus_busy;
  logic                   bus_timeout;

  modport slave (
    input  m_req,
    input  m_as,
    input  s_ready,
    output m_grnt,
    output owner,
    output bus_busy,
    output bus_timeout
  );

  modport master (
    output m_req,
    output m_as,
    output s_ready,
    input  m_grnt,
    input  owner,
    input  bus_busy,
    input  bus_timeout
  );

endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus.
//
// Grants the bus to one of NUM_MASTERS requesters, tracks each transfer from
// address strobe to slave ready, and aborts transfers whose ready stays low
// for TIMEOUT_CYCLES consecutive cycles. All outputs are registered; owner
// steers the master-side address/data mux.
//
// Ports:
//   clk    bus clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    bus_arbiter_if.slave (m_req, m_as, s_ready in;
//          m_grnt, owner, bus_busy, bus_timeout out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner, m_grnt = 0, waiting for any request
// ST_GRANT | owner holds the bus between transfers; may start or release
// ST_XFER  | transfer in flight, waiting for s_ready or watchdog expiry
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int OWNER_W        = $clog2(NUM_MASTERS)
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OWNER_W-1:0]     OWNER_INIT = OWNER_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] GRNT_ONE   = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] m_grnt_q, m_grnt_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     last_owner_q, last_owner_d;
  logic [CNT_W-1:0]       wdog_cnt_q, wdog_cnt_d;
  logic                   bus_busy_q, bus_busy_d;
  logic                   bus_timeout_q, bus_timeout_d;

  logic                   any_req;
  logic                   owner_req;
  logic [OWNER_W-1:0]     winner;

  // First requester after `last`, wrapping modulo NUM_MASTERS. `last` itself
  // is scanned last, so a lone requester can win again.
  function automatic logic [OWNER_W-1:0] rr_pick(
    input logic [NUM_MASTERS-1:0] req,
    input logic [OWNER_W-1:0]     last
  );
    logic [OWNER_W-1:0] win;
    logic               found;
    int                 idx;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        win   = OWNER_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign any_req   = |bus.m_req;
  assign owner_req = bus.m_req[owner_q];
  assign winner    = rr_pick(bus.m_req, last_owner_q);

  always_comb begin
    state_d       = state_q;
    m_grnt_d      = m_grnt_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    wdog_cnt_d    = wdog_cnt_q;
    bus_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_GRANT;
          owner_d      = winner;
          last_owner_d = winner;
          m_grnt_d     = GRNT_ONE << winner;
        end
      end

      ST_GRANT: begin
        // A strobe in the same cycle as the request drop still starts the
        // transfer; the release is then seen after the transfer ends.
        if (bus.m_as) begin
          state_d    = ST_XFER;
          wdog_cnt_d = '0;
        end else if (!owner_req) begin
          if (any_req) begin
            // Hand over directly, no idle cycle between tenures.
            owner_d      = winner;
            last_owner_d = winner;
            m_grnt_d     = GRNT_ONE << winner;
          end else begin
            state_d  = ST_IDLE;
            m_grnt_d = '0;
          end
        end
      end

      ST_XFER: begin
        if (bus.s_ready) begin
          state_d    = ST_GRANT;
          wdog_cnt_d = '0;
        end else if (wdog_cnt_q == CNT_LAST) begin
          // This is the TIMEOUT_CYCLES-th consecutive low-ready cycle.
          state_d       = ST_GRANT;
          wdog_cnt_d    = '0;
          bus_timeout_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        m_grnt_d = '0;
      end
    endcase

    bus_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      m_grnt_q      <= '0;
      owner_q       <= '0;
      last_owner_q  <= OWNER_INIT;
      wdog_cnt_q    <= '0;
      bus_busy_q    <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_grnt_q      <= m_grnt_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      wdog_cnt_q    <= wdog_cnt_d;
      bus_busy_q    <= bus_busy_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  assign bus.m_grnt      = m_grnt_q;
  assign bus.owner       = owner_q;
  assign bus.bus_busy    = bus_busy_q;
  assign bus.bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int OW = $clog2(N);

  logic clk = 1'b0;
  logic reset;

  bus_arbiter_if #(.NUM_MASTERS(N), .OWNER_W(OW)) bif ();

  bus_arbiter #(
    .NUM_MASTERS(N),
    .TIMEOUT_CYCLES(T),
    .OWNER_W(OW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: who owns the bus, whether a transfer is in flight, how
  // many ready-low cycles it has seen, and whether a timeout was just flagged.
  bit m_owned;
  bit m_in_xfer;
  int m_owner;
  int m_last;
  int m_low;
  int m_to;

  function automatic int next_winner(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int w;
    if (reset) begin
      m_owned = 0; m_in_xfer = 0; m_owner = 0; m_last = N - 1; m_low = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_owned) begin
        w = next_winner(bif.m_req, m_last);
        if (w >= 0) begin m_owned = 1; m_owner = w; m_last = w; end
      end else if (m_in_xfer) begin
        if (bif.s_ready) begin
          m_in_xfer = 0; m_low = 0;
        end else begin
          m_low++;
          if (m_low == T) begin m_in_xfer = 0; m_low = 0; m_to = 1; end
        end
      end else if (bif.m_as) begin
        m_in_xfer = 1; m_low = 0;
      end else if (!bif.m_req[m_owner]) begin
        w = next_winner(bif.m_req, m_last);
        if (w >= 0) begin m_owner = w; m_last = w; end
        else m_owned = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("model_grnt",    int'(bif.m_grnt),      m_owned ? (1 << m_owner) : 0);
      check("model_owner",   int'(bif.owner),       m_owner);
      check("model_busy",    int'(bif.bus_busy),    int'(m_owned));
      check("model_timeout", int'(bif.bus_timeout), m_to);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int idx;
  bit low_rdy;

  initial begin
    reset = 1'b1;
    bif.m_req = '0; bif.m_as = 1'b0; bif.s_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("reset_grnt",  int'(bif.m_grnt), 0);
    check("reset_owner", int'(bif.owner), 0);
    check("reset_busy",  int'(bif.bus_busy), 0);

    // first grant and handover
    reset = 1'b0;
    bif.m_req = 4'b0101; step();
    check("first_grnt", int'(bif.m_grnt), 1);
    check("first_owner", int'(bif.owner), 0);
    bif.m_req = 4'b0100; step();
    check("handover_grnt", int'(bif.m_grnt), 4);
    check("handover_owner", int'(bif.owner), 2);
    bif.m_req = 4'b0000; step();
    check("idle_grnt", int'(bif.m_grnt), 0);
    check("idle_busy", int'(bif.bus_busy), 0);
    check("idle_owner_kept", int'(bif.owner), 2);

    // wrap-around from last owner 3
    bif.m_req = 4'b1000; step();
    check("owner3", int'(bif.owner), 3);
    bif.m_req = 4'b0000; step();
    bif.m_req = 4'b1001; step();
    check("wrap_grnt", int'(bif.m_grnt), 1);
    bif.m_req = 4'b0000; step();

    // round-robin order with one transfer per tenure
    reset = 1'b1; step();
    reset = 1'b0; bif.m_req = 4'b1111; step();
    for (int k = 0; k < 5; k++) begin
      check("rr_owner", int'(bif.owner), exp_order[k]);
      check("rr_grnt", int'(bif.m_grnt), 1 << exp_order[k]);
      if (k < 4) begin
        bif.m_as = 1'b1; step();
        check("rr_xfer_busy", int'(bif.bus_busy), 1);
        bif.m_as = 1'b0; bif.s_ready = 1'b1; step();
        bif.s_ready = 1'b0; bif.m_req[exp_order[k]] = 1'b0; step();
        bif.m_req = 4'b1111;
      end
    end

    // transfer of 3 cycles, request dropped mid-transfer
    bif.m_req = 4'b1110; step();
    check("xfer_owner", int'(bif.owner), 1);
    bif.m_as = 1'b1; step();
    bif.m_as = 1'b0; bif.m_req = 4'b1100;
    step(); check("xfer_hold1", int'(bif.m_grnt), 2);
    step(); check("xfer_hold2", int'(bif.m_grnt), 2);
    bif.s_ready = 1'b1; step();
    check("xfer_done_grnt", int'(bif.m_grnt), 2);
    check("xfer_done_to", int'(bif.bus_timeout), 0);
    bif.s_ready = 1'b0; step();
    check("after_xfer_owner", int'(bif.owner), 2);

    // watchdog timeout
    bif.m_as = 1'b1; step();
    bif.m_as = 1'b0;
    for (int i = 1; i < T; i++) begin
      step(); check("to_quiet", int'(bif.bus_timeout), 0);
    end
    step();
    check("to_pulse", int'(bif.bus_timeout), 1);
    check("to_grnt", int'(bif.m_grnt), 4);
    step();
    check("to_pulse_end", int'(bif.bus_timeout), 0);

    // ready on the would-be timeout cycle
    bif.m_as = 1'b1; step();
    bif.m_as = 1'b0;
    for (int i = 1; i < T; i++) step();
    bif.s_ready = 1'b1; step();
    check("late_rdy_no_to", int'(bif.bus_timeout), 0);
    bif.s_ready = 1'b0; step();
    check("late_rdy_no_to2", int'(bif.bus_timeout), 0);

    // strobe and request drop together
    bif.m_as = 1'b1; bif.m_req = 4'b1000; step();
    check("simul_grnt", int'(bif.m_grnt), 4);
    check("simul_busy", int'(bif.bus_busy), 1);
    bif.m_as = 1'b0; bif.s_ready = 1'b1; step();
    bif.s_ready = 1'b0; step();
    check("simul_release", int'(bif.owner), 3);
    bif.m_req = 4'b0000; step();
    check("release_idle_grnt", int'(bif.m_grnt), 0);
    check("release_idle_busy", int'(bif.bus_busy), 0);

    // reset mid-transfer
    bif.m_req = 4'b1111; step();
    bif.m_as = 1'b1; step();
    bif.m_as = 1'b0; reset = 1'b1; step();
    check("rst_xfer_grnt", int'(bif.m_grnt), 0);
    check("rst_xfer_owner", int'(bif.owner), 0);
    check("rst_xfer_busy", int'(bif.bus_busy), 0);
    check("rst_xfer_to", int'(bif.bus_timeout), 0);
    reset = 1'b0; step();
    check("rst_first_grnt", int'(bif.m_grnt), 1);

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, N - 1);
        bif.m_req[idx] = ~bif.m_req[idx];
      end
      low_rdy     = ((c / 500) % 2) == 1;
      bif.m_as    = ($urandom_range(0, 2) == 0);
      bif.s_ready = low_rdy ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
